gpio_expander_ctrl: RTL and testbench
=====================================

GPIO_EXPANDER_CTRL -- requirements
Module: gpio_expander_ctrl

Interface
REQ-001 Parameter CS_SETUP_CLKS, 4: i_Clk cycles from CS assert to first byte issue (>=1).
REQ-002 Parameter CS_HOLD_CLKS, 4: cycles from last i_RX_DV to CS deassert (>=2, covers delayed SPI clock).
REQ-003 Parameter CS_IDLE_CLKS, 4: minimum CS-high cycles before next transaction (>=1).
REQ-004 Parameter TIMEOUT_CLKS, 1024: per-byte watchdog limit (only with GPIO_EXP_TIMEOUT_EN).
REQ-005 i_Clk  in  1  single clock; all logic rising-edge.
REQ-006 i_Rst  in  1  reset, synchronous, active-high.
REQ-007 i_Req  in  1  one-cycle transaction request pulse.
REQ-008 i_Wr  in  1  1=register write, 0=register read; sampled with i_Req.
REQ-009 i_Dev_Addr  in  3  expander hardware address; sampled with i_Req.
REQ-010 i_Reg_Addr  in  8  expander register address; sampled with i_Req.
REQ-011 i_Wr_Data  in  8  write data; sampled with i_Req.
REQ-012 o_Busy  out  1  high from request acceptance until return to IDLE.
REQ-013 o_Done  out  1  one-cycle completion pulse.
REQ-014 o_Rd_Data  out  8  read result; valid with o_Done, held until next o_Done.
REQ-015 o_TX_Byte  out  8  byte to SPI byte master.
REQ-016 o_TX_DV  out  1  one-cycle byte-valid pulse to SPI byte master.
REQ-017 i_TX_Ready  in  1  SPI byte master ready.
REQ-018 i_RX_DV, i_RX_Byte  in  1, 8  received-byte pulse and data from SPI byte master.
REQ-019 o_SPI_CS_n  out  1  expander chip select, active-low.
REQ-020 o_Err  out  1  sticky timeout flag (present only with GPIO_EXP_TIMEOUT_EN).

Function
REQ-021 FSM states: IDLE, CS_SETUP, SEND, WAIT_RX, CS_HOLD, CS_GAP.
REQ-022 IDLE: i_Req=1 latches inputs, drives o_SPI_CS_n=0, sets o_Busy=1, enters CS_SETUP next cycle; i_Req outside IDLE is ignored.
REQ-023 CS_SETUP lasts exactly CS_SETUP_CLKS cycles, then SEND with byte index 0.
REQ-024 Frame is 3 bytes: 0 = {4'b0100, Dev_Addr, ~Wr}; 1 = Reg_Addr; 2 = Wr_Data for write, 8'h00 for read.
REQ-025 SEND: when i_TX_Ready=1, pulse o_TX_DV for exactly one cycle with o_TX_Byte valid that cycle, then WAIT_RX.
REQ-026 WAIT_RX: on i_RX_DV, index 0/1 -> increment index, SEND; index 2 -> capture i_RX_Byte into o_Rd_Data (read only), CS_HOLD.
REQ-027 CS_HOLD lasts CS_HOLD_CLKS cycles; on exit o_SPI_CS_n=1 and o_Done pulses the same cycle; next state CS_GAP.
REQ-028 CS_GAP lasts CS_IDLE_CLKS cycles with o_Busy=1, then IDLE; o_Rd_Data unchanged on write transactions.
REQ-029 o_SPI_CS_n stays low continuously from CS_SETUP entry through CS_HOLD exit; never toggles between bytes.
REQ-030 i_RX_DV outside WAIT_RX is ignored.

Reset
REQ-031 On i_Rst: state IDLE, o_SPI_CS_n=1, o_Busy=0, o_Done=0, o_TX_DV=0, o_TX_Byte=8'h00, o_Rd_Data=8'h00, o_Err=0, counters cleared.
REQ-032 Reset mid-transaction aborts it: CS deasserts the cycle after i_Rst sampled, no o_Done.

Configuration
REQ-033 Macro GPIO_EXP_TIMEOUT_EN defined: WAIT_RX counts cycles; TIMEOUT_CLKS without i_RX_DV -> set o_Err, deassert CS, go CS_GAP, no o_Done; o_Err cleared only by i_Rst.
REQ-034 Macro undefined: no watchdog, no o_Err port, WAIT_RX waits indefinitely.

Structure
REQ-035 Package gpio_exp_pkg holds state enum, opcode prefix 4'b0100, frame length constant 3, read/write bit encoding.
REQ-036 One sub-module gpio_exp_timer: loadable down-counter with zero flag, shared by CS_SETUP/CS_HOLD/CS_GAP/timeout.

Verification
REQ-037 Write: Dev=3'b001, Reg=8'h12, Data=8'hA5 -> bytes 0x42,0x12,0xA5 under one CS-low window, one o_Done, o_Rd_Data unchanged.
REQ-038 Read: Dev=3'b000, Reg=8'h09, slave returns 0x3C on byte 2 -> bytes 0x41,0x09,0x00, o_Rd_Data=8'h3C with o_Done.
REQ-039 i_Req asserted during WAIT_RX -> ignored; exactly one frame and one o_Done.
REQ-040 Back-to-back requests -> CS high >= CS_IDLE_CLKS cycles between frames; CS low >= CS_SETUP_CLKS before first o_TX_DV.
REQ-041 i_Rst pulsed after byte 1 -> CS high next cycle, all outputs at reset values, no o_Done.
REQ-042 GPIO_EXP_TIMEOUT_EN, TIMEOUT_CLKS=16, i_RX_DV withheld -> o_Err=1 after 16 cycles in WAIT_RX, CS high, no o_Done.

Source files
------------

// File: rtl/gpio_exp_pkg.sv
// Shared types and constants for the GPIO expander SPI controller.
package gpio_exp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SEND,
    S_WAIT_RX,
    S_CS_HOLD,
    S_CS_GAP
  } state_t;

  localparam logic [3:0]  OPCODE_PREFIX = 4'b0100;
  localparam int unsigned FRAME_LEN     = 3;
  localparam logic        RW_WRITE      = 1'b0;
  localparam logic        RW_READ       = 1'b1;
  localparam int unsigned TMR_W         = 16;

  // Byte idx of the 3-byte frame: opcode/address, register, data (0 on reads).
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [2:0] dev,
                                            input logic [7:0] reg_addr,
                                            input logic       wr,
                                            input logic [7:0] data);
    case (idx)
      2'd0:    return {OPCODE_PREFIX, dev, (wr ? RW_WRITE : RW_READ)};
      2'd1:    return reg_addr;
      default: return wr ? data : 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/gpio_expander_ctrl_if.sv
// Byte-level link between the controller and the SPI byte master.
interface gpio_expander_ctrl_if;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       i_TX_Ready;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;

  modport master (output o_TX_Byte, o_TX_DV,
                  input  i_TX_Ready, i_RX_DV, i_RX_Byte);
  modport slave  (input  o_TX_Byte, o_TX_DV,
                  output i_TX_Ready, i_RX_DV, i_RX_Byte);
endinterface

// File: rtl/gpio_exp_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module gpio_exp_timer
  import gpio_exp_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Val,
  output logic         o_Zero
);

  logic [W-1:0] r_Count;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Count <= '0;
    end else if (i_Load) begin
      r_Count <= i_Load_Val;
    end else if (r_Count != '0) begin
      r_Count <= r_Count - W'(1);
    end
  end

  assign o_Zero = (r_Count == '0);

endmodule

// File: rtl/gpio_expander_ctrl.sv
// SPI GPIO expander transaction controller: one 3-byte frame per request
// under a single CS-low window. Optional per-byte watchdog and sticky o_Err
// port when GPIO_EXP_TIMEOUT_EN is defined.
module gpio_expander_ctrl
  import gpio_exp_pkg::*;
#(
  parameter int unsigned CS_SETUP_CLKS = 4,
  parameter int unsigned CS_HOLD_CLKS  = 4,
  parameter int unsigned CS_IDLE_CLKS  = 4,
  parameter int unsigned TIMEOUT_CLKS  = 1024
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Req,
  input  logic                        i_Wr,
  input  logic [2:0]                  i_Dev_Addr,
  input  logic [7:0]                  i_Reg_Addr,
  input  logic [7:0]                  i_Wr_Data,
  output logic                        o_Busy,
  output logic                        o_Done,
  output logic [7:0]                  o_Rd_Data,
  gpio_expander_ctrl_if.master        io_Spi,
  output logic                        o_SPI_CS_n
`ifdef GPIO_EXP_TIMEOUT_EN
  ,
  output logic                        o_Err
`endif
);

  // Timers are loaded with N-1 on state entry so each timed state lasts N cycles.
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP_CLKS - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD_CLKS - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(CS_IDLE_CLKS - 1);
  localparam logic [TMR_W-1:0] TMO_LD   = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [1:0]       LAST_IDX = 2'(FRAME_LEN - 1);

  state_t     r_State;
  logic [1:0] r_Idx;
  logic       r_Wr;
  logic [2:0] r_Dev;
  logic [7:0] r_Reg;
  logic [7:0] r_Data;
  logic       r_Busy;
  logic       r_Done;
  logic [7:0] r_Rd_Data;
  logic [7:0] r_TX_Byte;
  logic       r_TX_DV;
  logic       r_Cs_n;
`ifdef GPIO_EXP_TIMEOUT_EN
  logic       r_Err;
`endif

  logic             w_Tmr_Load;
  logic [TMR_W-1:0] w_Tmr_Val;
  logic             w_Tmr_Zero;
  logic             w_Last;

  assign w_Last = (r_Idx == LAST_IDX);

  gpio_exp_timer #(.W(TMR_W)) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (w_Tmr_Load),
    .i_Load_Val (w_Tmr_Val),
    .o_Zero     (w_Tmr_Zero)
  );

  // Reload the shared timer on every transition into a timed state.
  always_comb begin
    w_Tmr_Load = 1'b0;
    w_Tmr_Val  = '0;
    case (r_State)
      S_IDLE: if (i_Req) begin
        w_Tmr_Load = 1'b1;
        w_Tmr_Val  = SETUP_LD;
      end
      S_SEND: if (io_Spi.i_TX_Ready) begin
        w_Tmr_Load = 1'b1;
        w_Tmr_Val  = TMO_LD;
      end
      S_WAIT_RX: begin
        if (io_Spi.i_RX_DV && w_Last) begin
          w_Tmr_Load = 1'b1;
          w_Tmr_Val  = HOLD_LD;
        end
`ifdef GPIO_EXP_TIMEOUT_EN
        else if (!io_Spi.i_RX_DV && w_Tmr_Zero) begin
          w_Tmr_Load = 1'b1;
          w_Tmr_Val  = GAP_LD;
        end
`endif
      end
      S_CS_HOLD: if (w_Tmr_Zero) begin
        w_Tmr_Load = 1'b1;
        w_Tmr_Val  = GAP_LD;
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State   <= S_IDLE;
      r_Idx     <= '0;
      r_Wr      <= 1'b0;
      r_Dev     <= '0;
      r_Reg     <= '0;
      r_Data    <= '0;
      r_Busy    <= 1'b0;
      r_Done    <= 1'b0;
      r_Rd_Data <= '0;
      r_TX_Byte <= '0;
      r_TX_DV   <= 1'b0;
      r_Cs_n    <= 1'b1;
`ifdef GPIO_EXP_TIMEOUT_EN
      r_Err     <= 1'b0;
`endif
    end else begin
      r_TX_DV <= 1'b0;
      r_Done  <= 1'b0;
      case (r_State)
        S_IDLE: if (i_Req) begin
          r_Wr    <= i_Wr;
          r_Dev   <= i_Dev_Addr;
          r_Reg   <= i_Reg_Addr;
          r_Data  <= i_Wr_Data;
          r_Idx   <= '0;
          r_Cs_n  <= 1'b0;
          r_Busy  <= 1'b1;
          r_State <= S_CS_SETUP;
        end
        S_CS_SETUP: if (w_Tmr_Zero) begin
          r_Idx   <= '0;
          r_State <= S_SEND;
        end
        S_SEND: if (io_Spi.i_TX_Ready) begin
          r_TX_Byte <= frame_byte(r_Idx, r_Dev, r_Reg, r_Wr, r_Data);
          r_TX_DV   <= 1'b1;
          r_State   <= S_WAIT_RX;
        end
        S_WAIT_RX: begin
          if (io_Spi.i_RX_DV) begin
            if (w_Last) begin
              if (!r_Wr) r_Rd_Data <= io_Spi.i_RX_Byte;
              r_State <= S_CS_HOLD;
            end else begin
              r_Idx   <= r_Idx + 2'd1;
              r_State <= S_SEND;
            end
          end
`ifdef GPIO_EXP_TIMEOUT_EN
          else if (w_Tmr_Zero) begin
            r_Err   <= 1'b1;
            r_Cs_n  <= 1'b1;
            r_State <= S_CS_GAP;
          end
`endif
        end
        S_CS_HOLD: if (w_Tmr_Zero) begin
          r_Cs_n  <= 1'b1;
          r_Done  <= 1'b1;
          r_State <= S_CS_GAP;
        end
        S_CS_GAP: if (w_Tmr_Zero) begin
          r_Busy  <= 1'b0;
          r_State <= S_IDLE;
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_Busy           = r_Busy;
  assign o_Done           = r_Done;
  assign o_Rd_Data        = r_Rd_Data;
  assign o_SPI_CS_n       = r_Cs_n;
  assign io_Spi.o_TX_Byte = r_TX_Byte;
  assign io_Spi.o_TX_DV   = r_TX_DV;
`ifdef GPIO_EXP_TIMEOUT_EN
  assign o_Err            = r_Err;
`endif

endmodule

// File: tb/tb_gpio_expander_ctrl.sv
// Directed bench for gpio_expander_ctrl with a behavioural SPI byte master.
module tb_gpio_expander_ctrl;

  localparam int unsigned SETUP = 4;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAP   = 4;
  localparam int unsigned TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       wr  = 1'b0;
  logic [2:0] dev = '0;
  logic [7:0] reg_a = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, cs_n;
  logic [7:0] rd;
`ifdef GPIO_EXP_TIMEOUT_EN
  logic       err;
`endif

  gpio_expander_ctrl_if bus();

  gpio_expander_ctrl #(
    .CS_SETUP_CLKS (SETUP),
    .CS_HOLD_CLKS  (HOLD),
    .CS_IDLE_CLKS  (GAP),
    .TIMEOUT_CLKS  (TMO)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Req      (req),
    .i_Wr       (wr),
    .i_Dev_Addr (dev),
    .i_Reg_Addr (reg_a),
    .i_Wr_Data  (wdata),
    .o_Busy     (busy),
    .o_Done     (done),
    .o_Rd_Data  (rd),
    .io_Spi     (bus),
    .o_SPI_CS_n (cs_n)
`ifdef GPIO_EXP_TIMEOUT_EN
    ,
    .o_Err      (err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Monitor: done pulses, CS windows, issued bytes.
  int         done_cnt = 0;
  int         fall_cnt = 0;
  int         hi_run = 0;
  int         lo_run = 0;
  int         last_gap = 0;
  int         last_setup = 0;
  int         frame_tx = 0;
  logic [7:0] done_rd = '0;
  logic [7:0] tx_log[$];
  logic       prev_cs = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        done_rd = rd;
      end
      if (cs_n === 1'b0) begin
        if (prev_cs) begin
          fall_cnt++;
          last_gap = hi_run;
          frame_tx = 0;
          lo_run   = 0;
        end
        lo_run++;
        hi_run = 0;
      end else begin
        hi_run++;
      end
      if (bus.o_TX_DV === 1'b1) begin
        tx_log.push_back(bus.o_TX_Byte);
        if (frame_tx == 0) last_setup = lo_run - 1;
        frame_tx++;
      end
      prev_cs = cs_n;
    end
  end

  // Responder: answers each byte 3 cycles later; byte 2 of a frame returns rd_resp.
  logic       rx_en = 1'b1;
  logic [7:0] rd_resp = 8'h00;
  int         rcnt = 0;

  initial begin
    bus.i_TX_Ready = 1'b1;
    bus.i_RX_DV    = 1'b0;
    bus.i_RX_Byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (cs_n) rcnt = 0;
      if (rx_en && bus.o_TX_DV === 1'b1) begin
        repeat (3) @(negedge clk);
        bus.i_RX_Byte = (rcnt == 2) ? rd_resp : 8'hFF;
        bus.i_RX_DV   = 1'b1;
        rcnt++;
        @(negedge clk);
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
      end
    end
  end

  task automatic start_txn(input logic w, input logic [2:0] d, input logic [7:0] r,
                           input logic [7:0] dat);
    wr = w; dev = d; reg_a = r; wdata = dat; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
    logic [7:0] exp_b[3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    check({tag, "_nbytes"}, tx_log.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < tx_log.size()) check($sformatf("%s_byte%0d", tag, i), {24'd0, tx_log[i]}, {24'd0, exp_b[i]});
      else                   check($sformatf("%s_byte%0d", tag, i), 32'hDEAD, {24'd0, exp_b[i]});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},    {31'd0, cs_n},           32'd1);
    check({tag, "_busy"},    {31'd0, busy},           32'd0);
    check({tag, "_done"},    {31'd0, done},           32'd0);
    check({tag, "_tx_dv"},   {31'd0, bus.o_TX_DV},    32'd0);
    check({tag, "_tx_byte"}, {24'd0, bus.o_TX_Byte},  32'd0);
    check({tag, "_rd"},      {24'd0, rd},             32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, d0, n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
`ifdef GPIO_EXP_TIMEOUT_EN
    check("rst_err", {31'd0, err}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Write: dev 1, reg 0x12, data 0xA5
    tx_log.delete(); f0 = fall_cnt; d0 = done_cnt; rd_resp = 8'h77;
    start_txn(1'b1, 3'b001, 8'h12, 8'hA5);
    check("wr_accept_busy", {31'd0, busy}, 32'd1);
    check("wr_accept_cs",   {31'd0, cs_n}, 32'd0);
    wait_done("wr");
    wait_idle("wr");
    check_frame("wr", 8'h42, 8'h12, 8'hA5);
    check("wr_cs_windows", fall_cnt - f0, 32'd1);
    check("wr_done_cnt",   done_cnt - d0, 32'd1);
    check("wr_rd_kept",    {24'd0, rd},   32'h00);

    // Read: dev 0, reg 0x09, slave returns 0x3C
    tx_log.delete(); f0 = fall_cnt; d0 = done_cnt; rd_resp = 8'h3C;
    start_txn(1'b0, 3'b000, 8'h09, 8'hEE);
    wait_done("rd");
    check("rd_data_at_done", {24'd0, rd}, 32'h3C);
    wait_idle("rd");
    check_frame("rd", 8'h41, 8'h09, 8'h00);
    check("rd_done_cnt",   done_cnt - d0, 32'd1);
    check("rd_done_rd",    {24'd0, done_rd}, 32'h3C);

    // Write after read keeps the earlier read result
    tx_log.delete(); rd_resp = 8'h5A;
    start_txn(1'b1, 3'b111, 8'hFF, 8'h00);
    wait_done("wr2");
    wait_idle("wr2");
    check_frame("wr2", 8'h4E, 8'hFF, 8'h00);
    check("wr2_rd_kept", {24'd0, rd}, 32'h3C);

    // Request during WAIT_RX is ignored
    tx_log.delete(); f0 = fall_cnt; d0 = done_cnt; rd_resp = 8'h11;
    start_txn(1'b1, 3'b010, 8'h34, 8'h56);
    n = 0;
    while (bus.o_TX_DV !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ign_first_dv", {31'd0, bus.o_TX_DV}, 32'd1);
    start_txn(1'b0, 3'b101, 8'hAA, 8'h00);
    wait_done("ign");
    wait_idle("ign");
    repeat (20) @(negedge clk);
    check_frame("ign", 8'h44, 8'h34, 8'h56);
    check("ign_cs_windows", fall_cnt - f0, 32'd1);
    check("ign_done_cnt",   done_cnt - d0, 32'd1);

    // Back-to-back: CS gap = CS_IDLE_CLKS + 1 idle cycle, setup = CS_SETUP_CLKS + 1 send cycle
    tx_log.delete();
    start_txn(1'b1, 3'b011, 8'h01, 8'h11);
    wait_done("b2b_a");
    wait_idle("b2b_a");
    start_txn(1'b1, 3'b100, 8'h02, 8'h22);
    wait_done("b2b_b");
    wait_idle("b2b_b");
    check("b2b_cs_gap",   last_gap,   GAP + 1);
    check("b2b_cs_setup", last_setup, SETUP + 1);
    check("b2b_nbytes",   tx_log.size(), 32'd6);
    check("b2b_b_byte0",  (tx_log.size() > 3) ? {24'd0, tx_log[3]} : 32'hDEAD, 32'h48);

    // Reset after byte 1 is issued aborts the frame
    d0 = done_cnt; rd_resp = 8'h99;
    start_txn(1'b0, 3'b110, 8'h0B, 8'h00);
    n = 0;
    begin
      int n_dv = 0;
      while (n_dv < 2 && n < 200) begin
        @(negedge clk);
        n++;
        if (bus.o_TX_DV === 1'b1) n_dv++;
      end
      check("abort_byte1_seen", n_dv, 32'd2);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_idle_cs", {31'd0, cs_n}, 32'd1);

`ifdef GPIO_EXP_TIMEOUT_EN
    // Watchdog: responder silent, error after TIMEOUT_CLKS cycles in WAIT_RX
    rx_en = 1'b0; d0 = done_cnt;
    start_txn(1'b0, 3'b001, 8'h20, 8'h00);
    n = 0;
    while (bus.o_TX_DV !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_first_dv", {31'd0, bus.o_TX_DV}, 32'd1);
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_cs_high", {31'd0, cs_n}, 32'd1);
    wait_idle("tmo");
    repeat (5) @(negedge clk);
    check("tmo_no_done", done_cnt - d0, 32'd0);
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
    rx_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("tmo_err_cleared", {31'd0, err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
